// File: rtl/cordic_pkg.sv
// cordic_pkg: shared FSM encoding, Q4.20 angle constants and float exponent bounds
// for the angle range reducer and the CORDIC core.
package cordic_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CONVERT   = 3'd1,
        REDUCE1   = 3'd2,
        REDUCE2   = 3'd3,
        FOLD_PI   = 3'd4,
        FOLD_HALF = 3'd5,
        DONE      = 3'd6
    } reducer_state_t;

    localparam int Q_WIDTH = 24;

    localparam logic [Q_WIDTH-1:0] TWO_PI  = 24'h6487EE;
    localparam logic [Q_WIDTH-1:0] PI      = 24'h3243F7;
    localparam logic [Q_WIDTH-1:0] HALF_PI = 24'h1921FC;

    // Biased exponents: below EXP_MIN the value is under one Q4.20 LSB; EXP_UNITY
    // aligns the 24-bit significand with Q4.20; EXP_ERROR and up is >= 16.0, Inf or NaN.
    localparam logic [7:0] EXP_MIN   = 8'd107;
    localparam logic [7:0] EXP_UNITY = 8'd130;
    localparam logic [7:0] EXP_ERROR = 8'd131;

endpackage

// File: rtl/angle_range_reducer_if.sv
// angle_range_reducer_if: start/angle request and reduced-angle result bundle.
interface angle_range_reducer_if #(
    parameter int FLOAT_DATA_WIDTH  = 32,
    parameter int CORDIC_DATA_WIDTH = 24
);
    logic                         clk_en;
    logic [FLOAT_DATA_WIDTH-1:0]  angle;
    logic [CORDIC_DATA_WIDTH-1:0] scaled;
    logic                         sign;
    logic                         error;
    logic                         busy;
    logic                         done;

    modport master (output clk_en, angle, input scaled, sign, error, busy, done);
    modport slave  (input clk_en, angle, output scaled, sign, error, busy, done);
endinterface

// File: rtl/float_to_fixed.sv
// float_to_fixed: combinational IEEE-754 single magnitude -> unsigned Q4.20, with range error.
// Build option: ANGLE_REDUCER_ROUND_EN rounds half-up on the first shifted-out bit.
module float_to_fixed
    import cordic_pkg::*;
(
    input  logic [30:0]        i_bits,
    output logic [Q_WIDTH-1:0] o_magnitude,
    output logic               o_error
);
    logic [7:0] w_exp;
    logic [4:0] w_shift;
`ifdef ANGLE_REDUCER_ROUND_EN
    logic [Q_WIDTH:0] w_shifted;
    logic [Q_WIDTH:0] w_rounded;
`endif

    // NOTE: every output and temporary gets a default first so no path infers a latch.
    always_comb begin
        w_exp       = i_bits[30:23];
        w_shift     = '0;
        o_magnitude = '0;
        o_error     = 1'b0;
`ifdef ANGLE_REDUCER_ROUND_EN
        w_shifted   = '0;
        w_rounded   = '0;
`endif
        if (w_exp >= EXP_ERROR) begin
            o_error = 1'b1;
        end else if (w_exp >= EXP_MIN) begin
            w_shift = 5'(EXP_UNITY - w_exp);
`ifdef ANGLE_REDUCER_ROUND_EN
            // Low bit of w_shifted is the most significant bit shifted out.
            w_shifted   = {1'b1, i_bits[22:0], 1'b0} >> w_shift;
            w_rounded   = {1'b0, w_shifted[Q_WIDTH:1]} + (Q_WIDTH+1)'(w_shifted[0]);
            o_magnitude = w_rounded[Q_WIDTH] ? {Q_WIDTH{1'b1}} : w_rounded[Q_WIDTH-1:0];
`else
            o_magnitude = {1'b1, i_bits[22:0]} >> w_shift;
`endif
        end
    end

endmodule

// File: rtl/angle_range_reducer.sv
// angle_range_reducer: folds a float radian angle into [0, pi/2] Q4.20 plus a cosine
// negate flag, fixed 6-cycle latency. Build option: ANGLE_REDUCER_ROUND_EN (in float_to_fixed).
module angle_range_reducer
    import cordic_pkg::*;
#(
    parameter int FLOAT_DATA_WIDTH = 32,
    parameter int INTEGER_WIDTH    = 4,
    parameter int FRACTIONAL_WIDTH = 20
) (
    input logic                  clk,
    input logic                  rst,
    angle_range_reducer_if.slave bus
);
    localparam int CORDIC_DATA_WIDTH = INTEGER_WIDTH + FRACTIONAL_WIDTH;

    reducer_state_t r_state;
    reducer_state_t w_state_next;

    // Sign bit is never stored: cosine is even.
    logic [30:0]                  r_bits;
    logic [CORDIC_DATA_WIDTH-1:0] r_x;
    logic                         r_sign_work;
    logic                         r_error_work;
    logic [CORDIC_DATA_WIDTH-1:0] r_scaled;
    logic                         r_sign;
    logic                         r_error;
    logic                         r_busy;
    logic                         r_done;

    logic [CORDIC_DATA_WIDTH-1:0] w_magnitude;
    logic                         w_error;

    float_to_fixed u_float_to_fixed (
        .i_bits      (r_bits),
        .o_magnitude (w_magnitude),
        .o_error     (w_error)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:      if (bus.clk_en) w_state_next = CONVERT;
            CONVERT:   w_state_next = REDUCE1;
            REDUCE1:   w_state_next = REDUCE2;
            REDUCE2:   w_state_next = FOLD_PI;
            FOLD_PI:   w_state_next = FOLD_HALF;
            FOLD_HALF: w_state_next = DONE;
            DONE:      w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the working datapath
    // is reset too so an aborted operation leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bits       <= '0;
            r_x          <= '0;
            r_sign_work  <= 1'b0;
            r_error_work <= 1'b0;
            r_scaled     <= '0;
            r_sign       <= 1'b0;
            r_error      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.clk_en) begin
                        r_bits <= bus.angle[30:0];
                        r_busy <= 1'b1;
                    end
                end
                CONVERT: begin
                    r_x          <= w_magnitude;
                    r_error_work <= w_error;
                end
                REDUCE1, REDUCE2: begin
                    if (r_x >= TWO_PI) r_x <= r_x - TWO_PI;
                end
                FOLD_PI: begin
                    if (r_x > PI) r_x <= TWO_PI - r_x;
                end
                FOLD_HALF: begin
                    if (r_x > HALF_PI) begin
                        r_x         <= PI - r_x;
                        r_sign_work <= 1'b1;
                    end else begin
                        r_sign_work <= 1'b0;
                    end
                end
                DONE: begin
                    r_scaled <= r_x;
                    r_sign   <= r_sign_work;
                    r_error  <= r_error_work;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.scaled = r_scaled;
    assign bus.sign   = r_sign;
    assign bus.error  = r_error;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule
